// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - request size encodings
//   - response FSM state type
//   - byte-enable generation, store-lane replication, load extension
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } dmem_state_t;

    // Per-lane write enables for an aligned access at byte offset off.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << off;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-justified store data copied into every lane it could land in,
    // so the byte enables alone pick the destination.
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

    // Select the addressed lane(s) of a full row and sign/zero extend.
    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic        is_unsigned,
                                                input logic [1:0]  off,
                                                input logic [31:0] row);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = row[7:0];
            2'd1:    b = row[15:8];
            2'd2:    b = row[23:16];
            default: b = row[31:24];
        endcase
        h = off[1] ? row[31:16] : row[15:0];
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            SZ_WORD: res = row;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: one 8-bit lane of the data memory.
//   i_clock  rising-edge clock
//   i_we     write i_wdata to row i_row
//   i_re     read row i_row into o_rdata (registered, held otherwise)
//   i_row    row address
//   i_wdata  write byte
//   o_rdata  last read byte
// Contents are never reset.
module dmem_bank #(
    parameter int ROWS  = 262144,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             i_clock,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [ROW_W-1:0] i_row,
    input  logic [7:0]       i_wdata,
    output logic [7:0]       o_rdata
);

    logic [7:0] r_mem [ROWS];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_row] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_row];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed synchronous data memory with a valid/ready
// request port and a registered response port, one access outstanding.
//   clock, reset      rising-edge clock, synchronous active-high reset
//   req_*             request: valid/ready, write, addr, size, unsigned, wdata
//   resp_*            response: valid/ready, extended rdata, align/range errors
// Misaligned, illegal-size or out-of-range accesses never touch the array
// and return rdata 0 with the matching error flag(s).
//
// state    | meaning
// ST_EMPTY | no response pending, request port always ready
// ST_FULL  | response pending, ready only when it is taken this cycle
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int unsigned DEPTH_BYTES = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err_align,
    output logic        resp_err_range
);

    localparam int unsigned ROWS  = DEPTH_BYTES / 4;
    localparam int          ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;

    logic             w_accept;
    logic [31:0]      w_offset;
    logic             w_err_align;
    logic             w_err_range;
    logic             w_err;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_rep;
    logic             w_we;
    logic             w_re;
    logic [ROW_W-1:0] w_row;
    logic [31:0]      w_row_rdata;

    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [1:0]       r_off;
    logic             r_rd_ok;
    logic             r_err_align;
    logic             r_err_range;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range check.
    assign w_offset    = req_addr - BASE_ADDR;
    assign w_err_range = (w_offset >= 32'(DEPTH_BYTES));
    always_comb begin
        w_err_align = 1'b0;
        case (req_size)
            SZ_BYTE: w_err_align = 1'b0;
            SZ_HALF: w_err_align = w_offset[0];
            SZ_WORD: w_err_align = (w_offset[1:0] != 2'd0);
            default: w_err_align = 1'b1;
        endcase
    end
    assign w_err = w_err_align | w_err_range;

    assign w_be        = byte_en(req_size, w_offset[1:0]);
    assign w_wdata_rep = replicate(req_size, req_wdata);
    assign w_row       = w_offset[ROW_W+1:2];

    // Gating with reset drops a store that coincides with reset.
    assign w_we = w_accept & req_write & ~w_err & ~reset;
    assign w_re = w_accept & ~req_write & ~w_err & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b1;
        w_accept    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                req_ready = 1'b1;
                w_accept  = req_valid;
                if (req_valid) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                req_ready = resp_ready;
                w_accept  = req_valid & resp_ready;
                if (resp_ready && !req_valid) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        dmem_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .i_clock (clock),
            .i_we    (w_we & w_be[k]),
            .i_re    (w_re),
            .i_row   (w_row),
            .i_wdata (w_wdata_rep[8*k +: 8]),
            .o_rdata (w_row_rdata[8*k +: 8])
        );
    end

    // Response metadata only moves on accept; the bank read registers also
    // only move on accept, so a stalled response stays bit-stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_off       <= 2'd0;
            r_rd_ok     <= 1'b0;
            r_err_align <= 1'b0;
            r_err_range <= 1'b0;
        end else if (w_accept) begin
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_off       <= w_offset[1:0];
            r_rd_ok     <= ~req_write & ~w_err;
            r_err_align <= w_err_align;
            r_err_range <= w_err_range;
        end
    end

    assign resp_valid     = (r_state == ST_FULL);
    assign resp_err_align = r_err_align;
    assign resp_err_range = r_err_range;
    assign resp_rdata     = r_rd_ok ? load_extend(r_size, r_unsigned, r_off, w_row_rdata) : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int unsigned DEPTH = 4096;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err_align;
    logic        resp_err_range;

    dmem_ctrl #(
        .BASE_ADDR   (BASE),
        .DEPTH_BYTES (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err_align (resp_err_align),
        .resp_err_range (resp_err_range)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: byte array plus one pending response
    logic [7:0]  m_mem [DEPTH];
    logic        m_full = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_ea = 1'b0;
    logic        m_er = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                             input logic u, input logic [31:0] wd,
                             output logic [31:0] rd, output logic ea, output logic er);
        logic [31:0] off;
        int          n;
        logic [31:0] val;
        off = a - BASE;
        n   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        er  = (off >= DEPTH);
        ea  = (s == 2'd3) || ((off % n) != 0);
        rd  = 32'd0;
        if (!ea && !er) begin
            if (w) begin
                for (int i = 0; i < n; i++) m_mem[off + i] = 8'((wd >> (8 * i)) & 32'hFF);
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | (32'(m_mem[off + i]) << (8 * i));
                if (!u && n < 4 && val[8 * n - 1])
                    val = val | ~((32'd1 << (8 * n)) - 32'd1);
                rd = val;
            end
        end
    endtask

    // One clock: drive at negedge, model the accept, check outputs at the next negedge.
    task automatic cycle(input logic v, input logic w, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] wd, input logic rr);
        logic        exp_ready, acc, nea, ner;
        logic [31:0] nrd;
        req_valid = v; req_write = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = wd; resp_ready = rr;
        #1;
        exp_ready = !m_full || rr;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        acc = v && exp_ready;
        nrd = '0; nea = 1'b0; ner = 1'b0;
        if (acc) model_req(w, a, s, u, wd, nrd, nea, ner);
        @(negedge clock);
        if (acc) begin
            m_full = 1'b1; m_rdata = nrd; m_ea = nea; m_er = ner;
        end else if (rr) begin
            m_full = 1'b0;
        end
        check("resp_valid", 32'(resp_valid), 32'(m_full));
        if (m_full) begin
            check("resp_rdata", resp_rdata, m_rdata);
            check("resp_err_align", 32'(resp_err_align), 32'(m_ea));
            check("resp_err_range", 32'(resp_err_range), 32'(m_er));
        end
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] rd, input logic ea, input logic er);
        check({tag, ".valid"}, 32'(resp_valid), 32'd1);
        check({tag, ".rdata"}, resp_rdata, rd);
        check({tag, ".align"}, 32'(resp_err_align), 32'(ea));
        check({tag, ".range"}, 32'(resp_err_range), 32'(er));
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom % 8)
            0:       a = BASE - 32'($urandom_range(1, 16));
            1:       a = BASE + DEPTH + 32'($urandom_range(0, 15));
            2:       a = BASE + DEPTH - 32'd4 + 32'($urandom_range(0, 3));
            default: a = BASE + 32'($urandom_range(0, DEPTH - 1));
        endcase
        return a;
    endfunction

    initial begin
        logic [1:0] s;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.err_align", 32'(resp_err_align), 32'd0);
        check("rst.err_range", 32'(resp_err_range), 32'd0);
        reset = 1'b0;
        #1;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        @(negedge clock);

        // give every byte a known value, back to back
        for (int i = 0; i < DEPTH / 4; i++)
            cycle(1'b1, 1'b1, BASE + 32'(4 * i), 2'd2, 1'b0, $urandom, 1'b1);

        cycle(1'b1, 1'b1, BASE, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1);
        expect_resp("sw_base", 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, BASE, 2'd2, 1'b0, 32'd0, 1'b1);
        expect_resp("lw_base", 32'hDEADBEEF, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, BASE + 32'd4, 2'd2, 1'b0, 32'h11223344, 1'b1);
        cycle(1'b1, 1'b1, BASE + 32'd5, 2'd0, 1'b0, 32'h00000080, 1'b1);
        cycle(1'b1, 1'b0, BASE + 32'd4, 2'd2, 1'b0, 32'd0, 1'b1);
        expect_resp("lw_after_sb", 32'h11228044, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, BASE + 32'd5, 2'd0, 1'b0, 32'd0, 1'b1);
        expect_resp("lb", 32'hFFFFFF80, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, BASE + 32'd5, 2'd0, 1'b1, 32'd0, 1'b1);
        expect_resp("lbu", 32'h00000080, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, BASE + 32'd4, 2'd1, 1'b0, 32'd0, 1'b1);
        expect_resp("lh", 32'hFFFF8044, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, BASE + 32'd1, 2'd1, 1'b0, 32'd0, 1'b1);
        expect_resp("lh_misal", 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, BASE + 32'd2, 2'd2, 1'b0, 32'h55555555, 1'b1);
        expect_resp("sw_misal", 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, BASE, 2'd2, 1'b0, 32'd0, 1'b1);
        expect_resp("lw_unchanged", 32'hDEADBEEF, 1'b0, 1'b0);

        cycle(1'b1, 1'b0, 32'h00FF_FFFC, 2'd2, 1'b0, 32'd0, 1'b1);
        expect_resp("lw_below", 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, BASE + DEPTH, 2'd2, 1'b0, 32'd0, 1'b1);
        expect_resp("lw_end", 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, BASE, 2'd3, 1'b0, 32'd0, 1'b1);
        expect_resp("size3", 32'd0, 1'b1, 1'b0);

        // backpressure: response held while the next request waits
        cycle(1'b1, 1'b0, BASE + 32'd4, 2'd2, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, BASE, 2'd2, 1'b0, 32'd0, 1'b0);
            expect_resp("stall_hold", 32'h11228044, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, BASE, 2'd2, 1'b0, 32'd0, 1'b1);
        expect_resp("stall_release", 32'hDEADBEEF, 1'b0, 1'b0);

        // reset while FULL and stalled, with a store on the reset edge
        cycle(1'b1, 1'b0, BASE + 32'd4, 2'd2, 1'b0, 32'd0, 1'b1);
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = BASE;
        req_size = 2'd2; req_wdata = 32'hCAFEF00D; resp_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0; req_valid = 1'b0;
        m_full = 1'b0;
        #1;
        check("rstfull.resp_valid", 32'(resp_valid), 32'd0);
        check("rstfull.resp_rdata", resp_rdata, 32'd0);
        check("rstfull.err_align", 32'(resp_err_align), 32'd0);
        check("rstfull.err_range", 32'(resp_err_range), 32'd0);
        check("rstfull.req_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        cycle(1'b1, 1'b0, BASE, 2'd2, 1'b0, 32'd0, 1'b1);
        expect_resp("rst_store_dropped", 32'hDEADBEEF, 1'b0, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
            cycle(($urandom % 4) != 0, 1'($urandom % 2), rand_addr(), s,
                  1'($urandom % 2), $urandom, ($urandom % 4) != 0);
        end
        cycle(1'b0, 1'b0, BASE, 2'd2, 1'b0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
